// File: rtl/issue_grant_if.sv
// rtl/issue_grant_if.sv - issue grant handshake bundle between selection, grant stage and execute
// Ports (master = selection/execute side, slave = issue_grant):
//   flush, issue_ready_ (active low), head, exe_ready      : into the grant stage
//   issue_valid, issue_idx, issue_vec, inst_busy,
//   issue_clear, issue_cnt                                  : out of the grant stage
interface issue_grant_if #(
  parameter int IQ_DEPTH = 16
);
  localparam int IDX_W = $clog2(IQ_DEPTH);

  logic                flush;
  logic [IQ_DEPTH-1:0] issue_ready_;
  logic [IDX_W-1:0]    head;
  logic                exe_ready;
  logic                issue_valid;
  logic [IDX_W-1:0]    issue_idx;
  logic [IQ_DEPTH-1:0] issue_vec;
  logic [IQ_DEPTH-1:0] inst_busy;
  logic [IQ_DEPTH-1:0] issue_clear;
  logic [31:0]         issue_cnt;

  modport master (
    output flush, issue_ready_, head, exe_ready,
    input  issue_valid, issue_idx, issue_vec, inst_busy, issue_clear, issue_cnt
  );

  modport slave (
    input  flush, issue_ready_, head, exe_ready,
    output issue_valid, issue_idx, issue_vec, inst_busy, issue_clear, issue_cnt
  );
endinterface

// File: rtl/issue_grant.sv
// rtl/issue_grant.sv - oldest-ready pick into a one-entry issue latch with valid/ready release
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : issue_grant_if.slave (flush, ready vector, head, exe_ready in;
//            latch valid/index/one-hot, busy mask, clear pulse, issue count out)
module issue_grant #(
  parameter int IQ_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  issue_grant_if.slave  bus
);
  localparam int IDX_W = $clog2(IQ_DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IQ_DEPTH-1:0] vec_q, vec_d;
  logic [IQ_DEPTH-1:0] busy_q, busy_d;
  logic [IQ_DEPTH-1:0] clear_q, clear_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [IQ_DEPTH-1:0] cand;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                accept;
  logic                load;

  // Busy entries are masked here as well, so a selection that forgets to
  // mask its own feedback can never get the held entry granted twice.
  assign cand = ~bus.issue_ready_ & ~busy_q;

  // Circular age scan starting at head; the index wraps naturally because
  // IQ_DEPTH is a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < IQ_DEPTH; k++) begin
      scan_idx = bus.head + IDX_W'(k);
      if (!pick_found && cand[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign accept = (state_q == HOLD) && bus.exe_ready;
  // Refilling on the accept cycle gives one issue per clock.
  assign load   = pick_found && ((state_q == EMPTY) || accept);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    clear_d = '0;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      // Flush discards the latch; a coincident accept produces no clear and
      // is not counted since the whole queue is being emptied.
      state_d = EMPTY;
      idx_d   = '0;
      vec_d   = '0;
      busy_d  = '0;
    end else begin
      if (accept) begin
        clear_d = vec_q;
        cnt_d   = cnt_q + 32'd1;
      end
      if (load) begin
        state_d = HOLD;
        idx_d   = pick_idx;
        vec_d   = {{(IQ_DEPTH-1){1'b0}}, 1'b1} << pick_idx;
        busy_d  = {{(IQ_DEPTH-1){1'b0}}, 1'b1} << pick_idx;
      end else if (accept) begin
        state_d = EMPTY;
        idx_d   = '0;
        vec_d   = '0;
        busy_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= '0;
      clear_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.issue_valid = (state_q == HOLD);
  assign bus.issue_idx   = idx_q;
  assign bus.issue_vec   = vec_q;
  // Same content as issue_vec, kept as its own flop so the feedback path to
  // selection does not share a fanout tree with the execute-side outputs.
  assign bus.inst_busy   = busy_q;
  assign bus.issue_clear = clear_q;
  assign bus.issue_cnt   = cnt_q;
endmodule
